// File: rtl/adder_pipe_eval_pkg.sv
// Shared types and helpers for the adder-pipeline evaluation checker.
// Enumerations match the numeric codes presented on the checker's outputs.
package adder_pipe_eval_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MISMATCH  = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_TIMEOUT   = 3'd4
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // Counter add that pins at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [2:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-2){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/adder_pipe_checker_sync_fifo.sv
// Single-clock FIFO holding outstanding operations; a write into a full FIFO
// is accepted when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_ok_s   = rd_en_i && !empty_o && !clear_i;
  assign wr_ok_s   = wr_en_i && (!full_o || rd_ok_s) && !clear_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(wr_ok_s) - (AW+1)'(rd_ok_s);
    end
  end

  // Storage carries no reset; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/adder_pipe_checker.sv
// Scoreboard checker for a pipelined adder: queues issued operands, compares
// returned results against a reference sum and keeps pass/fail statistics.
module adder_pipe_checker
  import adder_pipe_eval_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 16,
  parameter int MAX_LAT = 64,
  parameter bit SUB     = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       inA,
  input  logic [WIDTH-1:0]       inB,
  input  logic                   Cin,
  input  logic                   out_valid,
  input  logic [WIDTH-1:0]       S,
  input  logic                   Cout,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   match,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   err_flag,
  output logic [2:0]             err_code,
  output logic [CNT_W-1:0]       first_err_idx,
  output logic [1:0]             state
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(MAX_LAT + 1);
  localparam int ENT_W = 2 * WIDTH + 1;

  logic [ENT_W-1:0] head_s;
  logic             full_s, empty_s;
  logic [WIDTH-1:0] head_a_s, head_b_s, opb_s;
  logic             head_c_s;
  logic [WIDTH:0]   ref_sum_s;
  logic             pop_ok_s, underflow_s, timeout_s, overflow_s, push_ok_s, rd_en_s;
  logic             match_s, mismatch_s, err_any_s;
  logic [2:0]       err_inc_s;
  logic [CW-1:0]    pending_next_s;
  logic [AGE_W-1:0] age_q, age_d;
  err_code_e        first_code_s, err_code_q;
  state_e           state_q, state_d;
  logic             match_q, mismatch_q, err_flag_q;
  logic [CNT_W-1:0] match_cnt_q, err_cnt_q, first_err_idx_q;

  // A timeout discards the head, so it frees a slot just like a result pop.
  assign pop_ok_s    = out_valid && !empty_s;
  assign underflow_s = out_valid && empty_s;
  assign timeout_s   = !empty_s && !pop_ok_s && (age_q == AGE_W'(MAX_LAT));
  assign rd_en_s     = pop_ok_s || timeout_s;
  assign overflow_s  = in_valid && full_s && !rd_en_s;
  assign push_ok_s   = in_valid && !overflow_s;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .wr_en_i   (push_ok_s),
    .wr_data_i ({inA, inB, Cin}),
    .rd_en_i   (rd_en_s),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (pending)
  );

  assign {head_a_s, head_b_s, head_c_s} = head_s;
  assign opb_s      = SUB ? ~head_b_s : head_b_s;
  assign ref_sum_s  = {1'b0, head_a_s} + {1'b0, opb_s} + {{WIDTH{1'b0}}, head_c_s};
  assign match_s    = pop_ok_s && (ref_sum_s == {Cout, S});
  assign mismatch_s = pop_ok_s && (ref_sum_s != {Cout, S});
  assign err_any_s  = mismatch_s || underflow_s || overflow_s || timeout_s;
  assign err_inc_s  = {2'b00, mismatch_s} + {2'b00, underflow_s} +
                      {2'b00, overflow_s} + {2'b00, timeout_s};
  assign pending_next_s = pending + CW'(push_ok_s) - CW'(rd_en_s);

  // Head age restarts whenever the head leaves or nothing is queued.
  always_comb begin
    age_d = age_q;
    if (rd_en_s || empty_s) begin
      age_d = '0;
    end else begin
      age_d = age_q + 1'b1;
    end
  end

  // Error priority when several fire in the same cycle.
  always_comb begin
    first_code_s = ERR_NONE;
    if (mismatch_s) begin
      first_code_s = ERR_MISMATCH;
    end else if (underflow_s) begin
      first_code_s = ERR_UNDERFLOW;
    end else if (overflow_s) begin
      first_code_s = ERR_OVERFLOW;
    end else if (timeout_s) begin
      first_code_s = ERR_TIMEOUT;
    end else begin
      first_code_s = ERR_NONE;
    end
  end

  // Next-state logic; any error forces FAIL, which only reset/clear leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (push_ok_s) state_d = ST_BUSY;
               else           state_d = ST_IDLE;
      ST_BUSY: if (pending_next_s == '0) state_d = ST_IDLE;
               else                      state_d = ST_BUSY;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase
    if (err_flag_q || err_any_s) begin
      state_d = ST_FAIL;
    end else begin
      state_d = state_d;
    end
  end

  // Compare pulses, statistics, first-error capture and state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q         <= 1'b0;
      mismatch_q      <= 1'b0;
      match_cnt_q     <= '0;
      err_cnt_q       <= '0;
      err_flag_q      <= 1'b0;
      err_code_q      <= ERR_NONE;
      first_err_idx_q <= '0;
      age_q           <= '0;
      state_q         <= ST_IDLE;
    end else if (clear) begin
      match_q         <= 1'b0;
      mismatch_q      <= 1'b0;
      match_cnt_q     <= '0;
      err_cnt_q       <= '0;
      err_flag_q      <= 1'b0;
      err_code_q      <= ERR_NONE;
      first_err_idx_q <= '0;
      age_q           <= '0;
      state_q         <= ST_IDLE;
    end else begin
      match_q     <= match_s;
      mismatch_q  <= mismatch_s;
      match_cnt_q <= match_s ? sat_add(match_cnt_q, 3'd1) : match_cnt_q;
      err_cnt_q   <= sat_add(err_cnt_q, err_inc_s);
      if (err_any_s && !err_flag_q) begin
        err_flag_q      <= 1'b1;
        err_code_q      <= first_code_s;
        first_err_idx_q <= match_cnt_q + err_cnt_q;
      end
      age_q   <= age_d;
      state_q <= state_d;
    end
  end

  assign match         = match_q;
  assign mismatch      = mismatch_q;
  assign match_cnt     = match_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign err_flag      = err_flag_q;
  assign err_code      = err_code_q;
  assign first_err_idx = first_err_idx_q;
  assign state         = state_q;

endmodule

// File: tb/tb_adder_pipe_checker.sv
// Directed plus random stimulus against a queue-based reference of the checker.
module tb_adder_pipe_checker;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int ML = 10;
  localparam bit SUBP = 1'b0;

  logic         clk = 1'b0;
  logic         reset, clear, in_valid, Cin, out_valid, Cout;
  logic [W-1:0] inA, inB, S;
  logic [2:0]   pending;
  logic         match, mismatch, err_flag;
  logic [31:0]  match_cnt, err_cnt, first_err_idx;
  logic [2:0]   err_code;
  logic [1:0]   state;

  adder_pipe_checker #(.WIDTH(W), .DEPTH(D), .MAX_LAT(ML), .SUB(SUBP)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .inA(inA),
    .inB(inB), .Cin(Cin), .out_valid(out_valid), .S(S), .Cout(Cout),
    .pending(pending), .match(match), .mismatch(mismatch), .match_cnt(match_cnt),
    .err_cnt(err_cnt), .err_flag(err_flag), .err_code(err_code),
    .first_err_idx(first_err_idx), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic c;} op_t;

  op_t         q[$];
  int          m_age;
  logic [31:0] m_mcnt, m_ecnt, m_idx;
  logic        m_match, m_mism, m_flag;
  logic [2:0]  m_code;
  logic [1:0]  m_st;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [W:0] ref_of(input op_t op);
    logic [W-1:0] bb;
    bb = SUBP ? ~op.b : op.b;
    return {1'b0, op.a} + {1'b0, bb} + {{W{1'b0}}, op.c};
  endfunction

  function automatic void model_clear();
    q.delete();
    m_age = 0; m_mcnt = 0; m_ecnt = 0; m_idx = 0;
    m_match = 0; m_mism = 0; m_flag = 0; m_code = 0; m_st = 0;
  endfunction

  function automatic void model_step();
    int n, nerr;
    bit pop, unf, tmo, ovf, push, ok, mis;
    longint esum;
    op_t op;
    if (clear) begin
      model_clear();
      return;
    end
    n   = q.size();
    pop = out_valid && n > 0;
    unf = out_valid && n == 0;
    tmo = !pop && n > 0 && m_age == ML;
    ok  = pop && ({Cout, S} === ref_of(q[0]));
    mis = pop && !ok;
    ovf = in_valid && n == D && !(pop || tmo);
    push = in_valid && !ovf;
    if (pop || tmo || n == 0) m_age = 0;
    else m_age++;
    if (pop || tmo) void'(q.pop_front());
    if (push) begin
      op.a = inA; op.b = inB; op.c = Cin;
      q.push_back(op);
    end
    nerr = int'(mis) + int'(unf) + int'(ovf) + int'(tmo);
    if (nerr > 0 && !m_flag) begin
      m_flag = 1;
      m_code = mis ? 3'd1 : (unf ? 3'd2 : (ovf ? 3'd3 : 3'd4));
      m_idx  = m_mcnt + m_ecnt;
    end
    m_match = pop && ok;
    m_mism  = mis;
    if (m_match && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    esum = longint'(m_ecnt) + longint'(nerr);
    m_ecnt = (esum > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : esum[31:0];
    if (m_flag) m_st = 2'd2;
    else if (m_st == 2'd0 && push) m_st = 2'd1;
    else if (m_st == 2'd1 && q.size() == 0) m_st = 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pending",       32'(pending),       32'(q.size()));
    chk("match",         32'(match),         32'(m_match));
    chk("mismatch",      32'(mismatch),      32'(m_mism));
    chk("match_cnt",     match_cnt,          m_mcnt);
    chk("err_cnt",       err_cnt,            m_ecnt);
    chk("err_flag",      32'(err_flag),      32'(m_flag));
    chk("err_code",      32'(err_code),      32'(m_code));
    chk("first_err_idx", first_err_idx,      m_idx);
    chk("state",         32'(state),         32'(m_st));
  endtask

  task automatic step(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit c, input bit ov, input logic [W-1:0] s,
                      input bit co, input bit clr);
    in_valid = iv; inA = a; inB = b; Cin = c;
    out_valid = ov; S = s; Cout = co; clear = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1);
  endtask

  // Return the correct result for the current head of the bench queue.
  task automatic ret_good(input bit iv, input op_t nxt);
    logic [W:0] r;
    r = ref_of(q[0]);
    step(iv, nxt.a, nxt.b, nxt.c, 1, r[W-1:0], r[W], 0);
  endtask

  initial begin
    op_t o;
    logic [W:0] r;
    reset = 1; clear = 0; in_valid = 0; out_valid = 0;
    inA = 0; inB = 0; Cin = 0; S = 0; Cout = 0;
    model_clear();
    #2;
    check_all();
    @(posedge clk); #1;
    reset = 0;

    // Basic match with a carry out
    step(1, 8'hFF, 8'h01, 0, 0, 8'h00, 0, 0);
    idle(2);
    step(0, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0);
    chk("s1_match", 32'(match), 32'd1);
    chk("s1_match_cnt", match_cnt, 32'd1);
    chk("s1_pending", 32'(pending), 32'd0);
    chk("s1_state", 32'(state), 32'd0);
    idle(1);
    do_clear();

    // Wrong result, then a correct one while in FAIL
    step(1, 8'h10, 8'h20, 1, 0, 8'h00, 0, 0);
    idle(1);
    step(0, 8'h00, 8'h00, 0, 1, 8'h30, 0, 0);
    chk("s2_mismatch", 32'(mismatch), 32'd1);
    chk("s2_err_code", 32'(err_code), 32'd1);
    chk("s2_first_idx", first_err_idx, 32'd0);
    chk("s2_state", 32'(state), 32'd2);
    step(1, 8'h01, 8'h02, 0, 0, 8'h00, 0, 0);
    step(0, 8'h00, 8'h00, 0, 1, 8'h03, 0, 0);
    chk("s2_match_cnt", match_cnt, 32'd1);
    chk("s2_still_fail", 32'(state), 32'd2);
    do_clear();

    // Underflow with a same-cycle push
    step(1, 8'h05, 8'h06, 0, 1, 8'h0B, 0, 0);
    chk("s3_err_code", 32'(err_code), 32'd2);
    chk("s3_err_cnt", err_cnt, 32'd1);
    chk("s3_pending", 32'(pending), 32'd1);
    do_clear();

    // Overflow, then push+pop while full
    for (int i = 1; i <= 5; i++) step(1, 8'(i * 17), 8'(i * 3), 0, 0, 8'h00, 0, 0);
    chk("s4_err_code", 32'(err_code), 32'd3);
    chk("s4_pending", 32'(pending), 32'd4);
    o.a = 8'h77; o.b = 8'h08; o.c = 1;
    ret_good(1, o);
    chk("s4_full_pp_pending", 32'(pending), 32'd4);
    chk("s4_full_pp_err_cnt", err_cnt, 32'd1);
    do_clear();

    // Timeout of a lone entry
    step(1, 8'h42, 8'h24, 1, 0, 8'h00, 0, 0);
    idle(ML);
    chk("s5_before_to", 32'(err_flag), 32'd0);
    idle(1);
    chk("s5_err_code", 32'(err_code), 32'd4);
    chk("s5_pending", 32'(pending), 32'd0);
    chk("s5_err_cnt", err_cnt, 32'd1);
    do_clear();

    // Asynchronous reset mid-stream, then clear in FAIL with a push present
    for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 8'(i + 2), 1, 0, 8'h00, 0, 0);
    in_valid = 0;
    reset = 1;
    #1;
    model_clear();
    check_all();
    chk("s6_reset_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    step(0, 8'h00, 8'h00, 0, 1, 8'h00, 0, 0);
    chk("s6_fail", 32'(state), 32'd2);
    step(1, 8'h12, 8'h34, 0, 0, 8'h00, 0, 1);
    chk("s6_clear_pending", 32'(pending), 32'd0);
    chk("s6_clear_err_cnt", err_cnt, 32'd0);
    chk("s6_clear_state", 32'(state), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit iv, ov, clr, co;
      logic [W-1:0] a, b, s;
      bit c;
      iv  = ($urandom_range(0, 1) == 1);
      ov  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 59) == 0);
      a = 8'($urandom); b = 8'($urandom); c = $urandom_range(0, 1) == 1;
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        r = ref_of(q[0]);
      end else begin
        r = 9'($urandom);
      end
      s = r[W-1:0]; co = r[W];
      step(iv, a, b, c, ov, s, co, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
